// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared types, constants and helpers for the loadable instruction memory
package prog_mem_pkg;

    typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

    localparam logic [7:0] HALT_OPCODE = 8'hFF;
    localparam int MAX_INSTR_WIDTH = 256;

    function automatic int calc_bpw(input int instr_width, input int byte_width);
        return instr_width / byte_width;
    endfunction

    // Opcode in the top byte, zeros below; callers truncate to their own width.
    function automatic logic [MAX_INSTR_WIDTH-1:0] halt_instr(input int instr_width);
        return {{(MAX_INSTR_WIDTH-8){1'b0}}, HALT_OPCODE} << (instr_width - 8);
    endfunction

endpackage

// File: rtl/prog_mem_loader_byte_word_assembler.sv
// byte_word_assembler: packs a serial byte stream (MSB first) into instruction words
//   clear         in   restart with an empty assembly register
//   byte_valid    in   shift byte_in into the low bits
//   word_done     out  this byte completes a word; word holds it
//   cnt_zero_next out  byte counter will be zero after this cycle
//   flush_word    out  partial word left-aligned and zero-padded
module byte_word_assembler #(
    parameter int INSTR_WIDTH = 32,
    parameter int BYTE_WIDTH  = 8,
    parameter int BPW         = 4
) (
    input  logic                   clk_150_mhz,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [BYTE_WIDTH-1:0]  byte_in,
    output logic                   word_done,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   cnt_zero_next,
    output logic [INSTR_WIDTH-1:0] flush_word
);

    localparam int CW = $clog2(BPW + 1);

    logic [INSTR_WIDTH-1:0] shreg;
    logic [CW-1:0]          cnt, cnt_next;

    // Stale bytes of the previous word shift out the top, so no clear is needed between words.
    always_comb begin
        word          = INSTR_WIDTH'({shreg, byte_in});
        word_done     = byte_valid && cnt == CW'(BPW - 1);
        cnt_next      = (clear || word_done) ? '0 : byte_valid ? cnt + 1'b1 : cnt;
        cnt_zero_next = cnt_next == '0;
        flush_word    = shreg << (BYTE_WIDTH * (BPW - int'(cnt)));
    end

    always_ff @(posedge clk_150_mhz or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            cnt <= cnt_next;
            if (clear)
                shreg <= '0;
            else if (byte_valid)
                shreg <= word;
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: serially loadable instruction memory with a registered fetch port
//   fetch_req/fetch_addr     in   fetch from the program counter (served only in RUN)
//   fetch_ready              out  RUN state, fetches accepted
//   fetch_valid/instruction  out  fetched word, one cycle after the request
//   load_start/load_end      in   pulses bracketing a program load
//   load_byte_valid/load_byte in  program bytes, most-significant byte of each word first
//   load_busy/load_done      out  loading in progress / load finished pulse
//   words_loaded             out  words written by the last load
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4096,
    parameter int ADDR_WIDTH  = 12,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic                   clk_150_mhz,
    input  logic                   rst_n,
    input  logic                   fetch_req,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   load_start,
    input  logic                   load_byte_valid,
    input  logic [BYTE_WIDTH-1:0]  load_byte,
    input  logic                   load_end,
    output logic                   load_busy,
    output logic                   load_done,
    output logic [ADDR_WIDTH:0]    words_loaded
);

    localparam int BPW = calc_bpw(INSTR_WIDTH, BYTE_WIDTH);
    localparam int MAW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = INSTR_WIDTH'(halt_instr(INSTR_WIDTH));

    state_t                 state, state_next;
    logic [ADDR_WIDTH:0]    wptr;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic                   clear, accept, we, word_done, cnt_zero_next, oob;
    logic [INSTR_WIDTH-1:0] word, flush_word, wdata;

    assign clear        = state == RUN && load_start;
    assign accept       = state == LOAD && load_byte_valid;
    assign fetch_ready  = state == RUN;
    assign load_busy    = state != RUN;
    assign words_loaded = wptr;
    assign oob          = {1'b0, fetch_addr} >= (ADDR_WIDTH+1)'(DEPTH);

    byte_word_assembler #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .BYTE_WIDTH  (BYTE_WIDTH),
        .BPW         (BPW)
    ) u_asm (
        .clk_150_mhz   (clk_150_mhz),
        .rst_n         (rst_n),
        .clear         (clear),
        .byte_valid    (accept),
        .byte_in       (load_byte),
        .word_done     (word_done),
        .word          (word),
        .cnt_zero_next (cnt_zero_next),
        .flush_word    (flush_word)
    );

    // Filling the last word ends the load even if load_end arrives in the same cycle.
    always_comb begin
        state_next = state;
        we         = 1'b0;
        wdata      = word;
        case (state)
            RUN:   state_next = load_start ? LOAD : RUN;
            LOAD: begin
                we = word_done;
                if (word_done && wptr == (ADDR_WIDTH+1)'(DEPTH - 1))
                    state_next = RUN;
                else if (load_end)
                    state_next = cnt_zero_next ? RUN : FLUSH;
            end
            FLUSH: begin
                we         = 1'b1;
                wdata      = flush_word;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_150_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wptr        <= '0;
            load_done   <= 1'b0;
            fetch_valid <= 1'b0;
            instruction <= '0;
        end else begin
            state       <= state_next;
            load_done   <= state != RUN && state_next == RUN;
            fetch_valid <= state == RUN && fetch_req;
            if (clear)
                wptr <= '0;
            else if (we)
                wptr <= wptr + 1'b1;
            if (state == RUN && fetch_req)
                instruction <= oob ? HALT_INSTR : mem[fetch_addr[MAW-1:0]];
        end
    end

    // Contents deliberately survive reset.
    always_ff @(posedge clk_150_mhz) begin
        if (we)
            mem[wptr[MAW-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: scoreboard bench for prog_mem_loader (default and DEPTH=4 instances)
module tb_prog_mem_loader;

    logic clk_150_mhz = 1'b0;
    always #3 clk_150_mhz = ~clk_150_mhz;

    logic        rst_n, sel4, fetch_req, load_start, load_byte_valid, load_end;
    logic [11:0] fetch_addr;
    logic [7:0]  load_byte;

    logic        m_ready, m_valid, m_busy, m_done;
    logic [31:0] m_instr;
    logic [12:0] m_wl;
    logic        d4_ready, d4_valid, d4_busy, d4_done;
    logic [31:0] d4_instr;
    logic [12:0] d4_wl;

    logic        t_ready, t_busy, t_done;
    logic [12:0] t_wl;
    assign t_ready = sel4 ? d4_ready : m_ready;
    assign t_busy  = sel4 ? d4_busy  : m_busy;
    assign t_done  = sel4 ? d4_done  : m_done;
    assign t_wl    = sel4 ? d4_wl    : m_wl;

    prog_mem_loader dut (
        .clk_150_mhz     (clk_150_mhz),
        .rst_n           (rst_n),
        .fetch_req       (fetch_req & ~sel4),
        .fetch_addr      (fetch_addr),
        .fetch_ready     (m_ready),
        .fetch_valid     (m_valid),
        .instruction     (m_instr),
        .load_start      (load_start & ~sel4),
        .load_byte_valid (load_byte_valid & ~sel4),
        .load_byte       (load_byte),
        .load_end        (load_end & ~sel4),
        .load_busy       (m_busy),
        .load_done       (m_done),
        .words_loaded    (m_wl)
    );

    prog_mem_loader #(.DEPTH(4)) dut4 (
        .clk_150_mhz     (clk_150_mhz),
        .rst_n           (rst_n),
        .fetch_req       (fetch_req & sel4),
        .fetch_addr      (fetch_addr),
        .fetch_ready     (d4_ready),
        .fetch_valid     (d4_valid),
        .instruction     (d4_instr),
        .load_start      (load_start & sel4),
        .load_byte_valid (load_byte_valid & sel4),
        .load_byte       (load_byte),
        .load_end        (load_end & sel4),
        .load_busy       (d4_busy),
        .load_done       (d4_done),
        .words_loaded    (d4_wl)
    );

    typedef struct {logic [31:0] d; bit care;} exp_t;
    exp_t        q[$], q4[$];
    exp_t        e_m, e_4;
    logic [7:0]  bq[$];
    logic [31:0] w4[$];
    int          n_vec = 0, n_err = 0, done_at;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_150_mhz) begin
        if (m_valid) begin
            if (q.size() == 0)
                check("m_unexpected_valid", 1, 0);
            else begin
                e_m = q.pop_front();
                if (e_m.care) check("m_instr", m_instr, e_m.d);
            end
        end
        if (d4_valid) begin
            if (q4.size() == 0)
                check("d4_unexpected_valid", 1, 0);
            else begin
                e_4 = q4.pop_front();
                if (e_4.care) check("d4_instr", d4_instr, e_4.d);
            end
        end
    end

    task automatic tick;
        @(posedge clk_150_mhz);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input bit care);
        if (sel4) q4.push_back('{d, care});
        else q.push_back('{d, care});
    endtask

    task automatic fetch(input logic [11:0] a, input logic [31:0] d);
        fetch_req  = 1'b1;
        fetch_addr = a;
        push_exp(d, 1'b1);
        tick;
        fetch_req = 1'b0;
    endtask

    task automatic start_load;
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
    endtask

    task automatic run_bytes;
        done_at = -1;
        for (int i = 0; i < bq.size(); i++) begin
            load_byte_valid = 1'b1;
            load_byte       = bq[i];
            tick;
            if (t_done && done_at < 0) done_at = i + 1;
        end
        load_byte_valid = 1'b0;
    endtask

    task automatic end_and_wait;
        int k = 0;
        load_end = 1'b1;
        tick;
        load_end = 1'b0;
        while (!t_done && k < 8) begin
            tick;
            k++;
        end
        check("load_done", t_done, 1);
        tick;
        check("load_done_pulse", t_done, 0);
    endtask

    initial begin
        rst_n = 1'b0; sel4 = 1'b0; fetch_req = 1'b0; load_start = 1'b0;
        load_byte_valid = 1'b0; load_end = 1'b0; fetch_addr = '0; load_byte = '0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        check("rst_ready", m_ready, 1);
        check("rst_valid", m_valid, 0);
        check("rst_instr", m_instr, 0);
        check("rst_busy", m_busy, 0);
        check("rst_done", m_done, 0);
        check("rst_wl", m_wl, 0);

        fetch_req = 1'b1; fetch_addr = 12'd0; push_exp('0, 1'b0);
        check("fv_before", m_valid, 0);
        tick;
        fetch_req = 1'b0;
        check("fv_rise", m_valid, 1);

        start_load;
        check("load_busy", t_busy, 1);
        check("load_ready", t_ready, 0);
        bq = '{8'h03, 8'h00, 8'h00, 8'h03, 8'h03, 8'h10, 8'h00, 8'h0A, 8'hFF, 8'h00, 8'h00, 8'h00};
        run_bytes;
        check("no_early_done", done_at, -1);
        end_and_wait;
        check("wl_three", t_wl, 3);
        fetch(12'd0, 32'h03000003);
        fetch(12'd1, 32'h0310000A);
        fetch(12'd2, 32'hFF000000);

        fetch_req = 1'b1; fetch_addr = 12'd1; push_exp(32'h0310000A, 1'b1);
        start_load;
        check("fetch_with_start", m_valid, 1);
        fetch_addr = 12'd0;
        bq = '{8'h06, 8'h20};
        for (int i = 0; i < 2; i++) begin
            load_byte_valid = 1'b1;
            load_byte       = bq[i];
            tick;
            check("ld_fetch_ready", t_ready, 0);
            check("ld_fetch_valid", m_valid, 0);
        end
        load_byte_valid = 1'b0;
        fetch_req = 1'b0;
        end_and_wait;
        check("wl_flush", t_wl, 1);
        fetch(12'd0, 32'h06200000);
        fetch(12'd1, 32'h0310000A);
        fetch(12'd2, 32'hFF000000);

        start_load;
        bq = '{8'h11, 8'h22, 8'h33};
        run_bytes;
        load_byte_valid = 1'b1; load_byte = 8'h44; load_end = 1'b1;
        tick;
        load_byte_valid = 1'b0; load_end = 1'b0;
        check("done_direct", t_done, 1);
        check("busy_direct", t_busy, 0);
        check("wl_direct", t_wl, 1);
        fetch(12'd0, 32'h11223344);

        load_end = 1'b1; load_byte_valid = 1'b1;
        tick;
        load_end = 1'b0; load_byte_valid = 1'b0;
        check("run_end_busy", t_busy, 0);
        check("run_end_done", t_done, 0);
        check("run_end_wl", t_wl, 1);

        sel4 = 1'b1;
        bq.delete();
        w4.delete();
        for (int i = 0; i < 20; i++) bq.push_back(8'(i * 7 + 1));
        for (int w = 0; w < 4; w++)
            w4.push_back({bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]});
        start_load;
        run_bytes;
        check("d4_done_at", done_at, 16);
        check("d4_done_once", t_done, 0);
        check("d4_wl", t_wl, 4);
        check("d4_busy", t_busy, 0);
        for (int w = 0; w < 4; w++) fetch(12'(w), w4[w]);
        fetch(12'd7, 32'hFF000000);
        fetch(12'd4095, 32'hFF000000);

        sel4 = 1'b0;
        start_load;
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h01};
        run_bytes;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", t_busy, 0);
        check("rst_mid_wl", t_wl, 0);
        check("rst_mid_ready", t_ready, 1);
        tick;
        rst_n = 1'b1;
        tick;
        fetch(12'd0, 32'hAABBCCDD);
        fetch(12'd1, 32'h0310000A);

        repeat (2) tick;
        check("scoreboard_drained", q.size() + q4.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
